// File: rtl/fp16_pkg.sv
// Shared FP16 constants and types used by the FP16 arithmetic and conversion blocks.
package fp16_pkg;

    localparam int FP16_EXP_W     = 5;
    localparam int FP16_FRAC_W    = 10;
    localparam int FP16_BIAS      = 15;
    localparam int FP16_EXP_MAX   = 31;
    // Exponent at which the 11-bit significand already sits at integer weight 1.
    localparam int FP16_INT_ALIGN = FP16_BIAS + FP16_FRAC_W;

    localparam logic [15:0] INT16_MAX = 16'h7FFF;
    localparam logic [15:0] INT16_MIN = 16'h8000;

    typedef enum logic [1:0] {
        F2I_IDLE     = 2'd0,
        F2I_CLASSIFY = 2'd1,
        F2I_SHIFT    = 2'd2,
        F2I_PACK     = 2'd3
    } f2i_state_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational FP16 operand classifier: zero, subnormal, infinity, NaN and 0<|v|<1.
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [FP16_EXP_W-1:0]  exp,
    input  logic [FP16_FRAC_W-1:0] frac,
    output logic                   is_zero,
    output logic                   is_sub,
    output logic                   is_inf,
    output logic                   is_nan,
    output logic                   lt_one
);

    localparam logic [FP16_EXP_W-1:0] EXP_ALL1 = FP16_EXP_W'(FP16_EXP_MAX);
    localparam logic [FP16_EXP_W-1:0] EXP_ONE  = FP16_EXP_W'(FP16_BIAS);

    logic frac_nz;

    always_comb begin
        frac_nz = (frac != '0);
        is_zero = (exp == '0) && !frac_nz;
        is_sub  = (exp == '0) && frac_nz;
        is_inf  = (exp == EXP_ALL1) && !frac_nz;
        is_nan  = (exp == EXP_ALL1) && frac_nz;
        // Normal numbers below 1.0 truncate to zero.
        lt_one  = (exp != '0) && (exp < EXP_ONE);
    end

endmodule

// File: rtl/hp_fp_to_int.sv
// FP16 to int16 converter: truncates toward zero, saturates, one shift step per cycle.
module hp_fp_to_int
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] in,
    output logic        done,
    output logic [15:0] result,
    output logic        overflow,
    output logic        inexact,
    output logic        invalid
);

    localparam logic [4:0] ALIGN = 5'(FP16_INT_ALIGN);

    f2i_state_t state, state_next;

    logic        sign_q;
    logic [4:0]  exp_q;
    logic [9:0]  frac_q;
    logic [16:0] mag;
    logic [4:0]  cnt;
    logic        special;
    logic [15:0] res_pre;

    logic is_zero, is_sub, is_inf, is_nan, lt_one;

    fp16_classify u_classify (
        .exp     (exp_q),
        .frac    (frac_q),
        .is_zero (is_zero),
        .is_sub  (is_sub),
        .is_inf  (is_inf),
        .is_nan  (is_nan),
        .lt_one  (lt_one)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= F2I_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            F2I_IDLE:     if (enable) state_next = F2I_CLASSIFY;
            F2I_CLASSIFY: begin
                if (is_inf || is_nan || is_zero || is_sub || lt_one) state_next = F2I_PACK;
                else                                                 state_next = F2I_SHIFT;
            end
            F2I_SHIFT:    if (cnt == ALIGN) state_next = F2I_PACK;
            F2I_PACK:     state_next = F2I_IDLE;
            default:      state_next = F2I_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            inexact  <= 1'b0;
            invalid  <= 1'b0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            frac_q   <= '0;
            mag      <= '0;
            cnt      <= '0;
            special  <= 1'b0;
            res_pre  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                F2I_IDLE: begin
                    if (enable) begin
                        sign_q   <= in[15];
                        exp_q    <= in[14:10];
                        frac_q   <= in[9:0];
                        overflow <= 1'b0;
                        inexact  <= 1'b0;
                        invalid  <= 1'b0;
                        special  <= 1'b0;
                        res_pre  <= '0;
                    end
                end
                F2I_CLASSIFY: begin
                    if (is_inf) begin
                        special  <= 1'b1;
                        res_pre  <= sign_q ? INT16_MIN : INT16_MAX;
                        overflow <= 1'b1;
                    end else if (is_nan) begin
                        special <= 1'b1;
                        invalid <= 1'b1;
                    end else if (is_zero || is_sub) begin
                        special <= 1'b1;
                        inexact <= is_sub;
                    end else if (lt_one) begin
                        special <= 1'b1;
                        inexact <= 1'b1;
                    end else begin
                        mag <= {6'b0, 1'b1, frac_q};
                        cnt <= exp_q;
                    end
                end
                F2I_SHIFT: begin
                    // Walk cnt toward the alignment exponent, one bit per cycle.
                    if (cnt < ALIGN) begin
                        mag     <= mag >> 1;
                        inexact <= inexact | mag[0];
                        cnt     <= cnt + 5'd1;
                    end else if (cnt > ALIGN) begin
                        mag <= mag << 1;
                        cnt <= cnt - 5'd1;
                    end
                end
                F2I_PACK: begin
                    done <= 1'b1;
                    if (special) begin
                        result <= res_pre;
                    end else if (!sign_q && (mag > 17'd32767)) begin
                        result   <= INT16_MAX;
                        overflow <= 1'b1;
                    end else if (sign_q && (mag > 17'd32768)) begin
                        result   <= INT16_MIN;
                        overflow <= 1'b1;
                    end else begin
                        // Two's-complement negate; -32768 and -0 fall out naturally.
                        result <= sign_q ? (~mag[15:0] + 16'd1) : mag[15:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hp_fp_to_int.sv
// Self-checking bench for hp_fp_to_int against an integer-arithmetic reference model.
module tb_hp_fp_to_int;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] in = 16'h0000;
    logic        done;
    logic [15:0] result;
    logic        overflow;
    logic        inexact;
    logic        invalid;

    int total = 0;
    int bad = 0;

    hp_fp_to_int dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .in       (in),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .inexact  (inexact),
        .invalid  (invalid)
    );

    always #5 clk = ~clk;

    // Reference: value = (1024+frac) * 2^(exp-25), truncated toward zero, clamped to int16.
    function automatic void ref_conv(input logic [15:0] x, output logic [15:0] r,
                                     output logic ov, output logic ix, output logic iv,
                                     output int lat);
        int e;
        int f;
        longint m;
        longint v;
        e = int'(x[14:10]);
        f = int'(x[9:0]);
        r = 16'h0000;
        ov = 1'b0;
        ix = 1'b0;
        iv = 1'b0;
        lat = 2;
        if (e == 31) begin
            if (f == 0) begin
                ov = 1'b1;
                r = x[15] ? 16'h8000 : 16'h7FFF;
            end else begin
                iv = 1'b1;
            end
        end else if (e == 0) begin
            ix = (f != 0);
        end else if (e < 15) begin
            ix = 1'b1;
        end else begin
            m = longint'(1024 + f);
            if (e >= 25) begin
                v = m * (longint'(1) << (e - 25));
                lat = 3 + (e - 25);
            end else begin
                v = m / (longint'(1) << (25 - e));
                ix = ((m % (longint'(1) << (25 - e))) != 0);
                lat = 3 + (25 - e);
            end
            if (x[15]) v = -v;
            if (v > 32767) begin
                r = 16'h7FFF;
                ov = 1'b1;
            end else if (v < -32768) begin
                r = 16'h8000;
                ov = 1'b1;
            end else begin
                r = v[15:0];
            end
        end
    endfunction

    // Starts one conversion and returns what the DUT reports at its done pulse.
    task automatic do_conv(input logic [15:0] x, output int lat, output logic [15:0] r,
                           output logic [2:0] flags);
        lat = -1;
        r = 16'h0000;
        flags = 3'b000;
        @(negedge clk);
        enable = 1'b1;
        in = x;
        @(posedge clk);
        #1;
        enable = 1'b0;
        in = 16'($urandom);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                r = result;
                flags = {overflow, inexact, invalid};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({done, result, overflow, inexact, invalid} !== 20'h0) begin
            $display("FAIL reset_outputs: got %h required 00000",
                     {done, result, overflow, inexact, invalid});
            bad++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] t_in  [12] = '{16'h3C00, 16'h4248, 16'hC500, 16'h7800, 16'hF800, 16'h7C00,
                                    16'hFC00, 16'h7E00, 16'h3800, 16'h8000, 16'h6400, 16'h7BFF};
        logic [15:0] t_res [12] = '{16'h0001, 16'h0003, 16'hFFFB, 16'h7FFF, 16'h8000, 16'h7FFF,
                                    16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0400, 16'h7FFF};
        logic [2:0]  t_flg [12] = '{3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b100,
                                    3'b100, 3'b001, 3'b010, 3'b000, 3'b000, 3'b100};
        int          t_lat [12] = '{13, 12, 11, 8, 8, 2, 2, 2, 2, 2, 3, 8};
        int          lat;
        logic [15:0] r;
        logic [2:0]  fl;
        for (int i = 0; i < 12; i++) begin
            do_conv(t_in[i], lat, r, fl);
            total += 3;
            if (r !== t_res[i]) begin
                $display("FAIL dir_result in=%h: got %h required %h", t_in[i], r, t_res[i]);
                bad++;
            end
            if (fl !== t_flg[i]) begin
                $display("FAIL dir_flags in=%h: got %b required %b", t_in[i], fl, t_flg[i]);
                bad++;
            end
            if (lat != t_lat[i]) begin
                $display("FAIL dir_latency in=%h: got %0d required %0d", t_in[i], lat, t_lat[i]);
                bad++;
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] x;
        logic [15:0] er;
        logic        eov, eix, eiv;
        int          elat;
        int          lat;
        logic [15:0] r;
        logic [2:0]  fl;
        for (int i = 0; i < 80; i++) begin
            x = 16'($urandom);
            if ($urandom_range(0, 3) != 0) x[14:10] = 5'($urandom_range(15, 30));
            ref_conv(x, er, eov, eix, eiv, elat);
            do_conv(x, lat, r, fl);
            total++;
            if ((r !== er) || (fl !== {eov, eix, eiv}) || (lat != elat)) begin
                $display("FAIL rand in=%h: got res=%h flags=%b lat=%0d required res=%h flags=%b lat=%0d",
                         x, r, fl, lat, er, {eov, eix, eiv}, elat);
                bad++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] xs [4] = '{16'hC500, 16'h6400, 16'h7E00, 16'h4248};
        logic [15:0] er;
        logic        eov, eix, eiv;
        int          elat;
        int          lat;
        logic [15:0] r;
        logic [2:0]  fl;
        // do_conv returns inside the done cycle, so each next enable lands on that cycle.
        for (int i = 0; i < 4; i++) begin
            ref_conv(xs[i], er, eov, eix, eiv, elat);
            do_conv(xs[i], lat, r, fl);
            total++;
            if ((r !== er) || (fl !== {eov, eix, eiv}) || (lat != elat)) begin
                $display("FAIL b2b in=%h: got res=%h flags=%b lat=%0d required res=%h flags=%b lat=%0d",
                         xs[i], r, fl, lat, er, {eov, eix, eiv}, elat);
                bad++;
            end
        end
    endtask

    task automatic test_busy_ignore();
        int          dones = 0;
        int          lat = -1;
        logic [15:0] r = 16'h0000;
        @(negedge clk);
        enable = 1'b1;
        in = 16'h3C00;
        @(posedge clk);
        #1;
        enable = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            enable = (n >= 2 && n <= 8);
            in = 16'h7800;
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                lat = n;
                r = result;
            end
        end
        enable = 1'b0;
        total += 3;
        if (dones != 1) begin
            $display("FAIL busy_done_count: got %0d required 1", dones);
            bad++;
        end
        if (lat != 13) begin
            $display("FAIL busy_latency: got %0d required 13", lat);
            bad++;
        end
        if (r !== 16'h0001) begin
            $display("FAIL busy_result: got %h required 0001", r);
            bad++;
        end
    endtask

    task automatic test_abort();
        int          dones = 0;
        int          lat;
        logic [15:0] r;
        logic [2:0]  fl;
        @(negedge clk);
        enable = 1'b1;
        in = 16'h3C00;
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({done, result, overflow, inexact, invalid} !== 20'h0) begin
            $display("FAIL abort_outputs: got %h required 00000",
                     {done, result, overflow, inexact, invalid});
            bad++;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        total++;
        if (dones != 0) begin
            $display("FAIL abort_no_done: got %0d pulses required 0", dones);
            bad++;
        end
        do_conv(16'h6400, lat, r, fl);
        total++;
        if ((r !== 16'h0400) || (fl !== 3'b000) || (lat != 3)) begin
            $display("FAIL abort_recover: got res=%h flags=%b lat=%0d required res=0400 flags=000 lat=3",
                     r, fl, lat);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
